// File: rtl/ddc_config_seq.sv
// Configuration sequencer for the DDC chain: clears the stage parameter registers,
// streams host frames onto the shared parameter bus, then commits and starts the NCO.
module ddc_config_seq #(
    parameter int COEBITWIDTH = 16,
    parameter int MAXWORDS    = 64,
    parameter int CLRCYCLES   = 4,
    parameter int STAGES      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_start,
    input  logic [COEBITWIDTH-1:0] cfg_data,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    output logic [COEBITWIDTH-1:0] param_bus,
    output logic [STAGES-1:0]      stage_ind,
    output logic                   config_sync,
    output logic                   param_clr_n,
    output logic                   start_n,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int N_W   = COEBITWIDTH - 4;
    localparam int SEL_W = $clog2(STAGES);
    localparam int CNT_W = $clog2(MAXWORDS + 1);
    localparam int CLR_W = $clog2(CLRCYCLES + 1);

    localparam logic [N_W-1:0] MAX_N      = N_W'(MAXWORDS);
    localparam logic [4:0]     NUM_STAGES = 5'(STAGES);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        HDR,
        DATA,
        SYNC,
        START,
        ERR
    } state_t;

    state_t             state;
    logic [CLR_W-1:0]   clr_cnt;
    logic [CNT_W-1:0]   word_cnt;
    logic [SEL_W-1:0]   stage_id;

    logic [3:0]         hdr_id;
    logic [N_W-1:0]     hdr_n;
    logic               is_marker;
    logic               hdr_ok;
    logic               accept;

    // Header fields: stage id in the top nibble, payload word count below it.
    always_comb begin
        hdr_id    = cfg_data[COEBITWIDTH-1 -: 4];
        hdr_n     = cfg_data[N_W-1:0];
        is_marker = (hdr_id == 4'hF);
        hdr_ok    = ({1'b0, hdr_id} < NUM_STAGES) && (hdr_n != '0) && (hdr_n <= MAX_N);
        accept    = cfg_valid & cfg_ready;
    end

    // NOTE: every output is a register updated with non-blocking assignments, so the
    // whole next state is computed from this cycle's values and outputs never glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            clr_cnt     <= '0;
            word_cnt    <= '0;
            stage_id    <= '0;
            cfg_ready   <= 1'b0;
            param_bus   <= '0;
            stage_ind   <= '0;
            config_sync <= 1'b0;
            param_clr_n <= 1'b1;
            start_n     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            // Single-cycle pulses default low; only a transfer or commit raises them.
            stage_ind   <= '0;
            config_sync <= 1'b0;
            done        <= 1'b0;

            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        busy        <= 1'b1;
                        err         <= 1'b0;
                        start_n     <= 1'b0;
                        param_clr_n <= 1'b0;
                        clr_cnt     <= CLR_W'(CLRCYCLES - 1);
                        state       <= CLR;
                    end
                end

                CLR: begin
                    if (clr_cnt == '0) begin
                        param_clr_n <= 1'b1;
                        cfg_ready   <= 1'b1;
                        state       <= HDR;
                    end else begin
                        clr_cnt <= clr_cnt - CLR_W'(1);
                    end
                end

                HDR: begin
                    if (accept) begin
                        if (is_marker) begin
                            cfg_ready <= 1'b0;
                            state     <= SYNC;
                        end else if (hdr_ok) begin
                            stage_id <= hdr_id[SEL_W-1:0];
                            word_cnt <= hdr_n[CNT_W-1:0];
                            state    <= DATA;
                        end else begin
                            cfg_ready <= 1'b0;
                            state     <= ERR;
                        end
                    end
                end

                DATA: begin
                    if (accept) begin
                        param_bus <= cfg_data;
                        stage_ind <= STAGES'(1) << stage_id;
                        word_cnt  <= word_cnt - CNT_W'(1);
                        if (word_cnt == CNT_W'(1)) begin
                            state <= HDR;
                        end
                    end
                end

                // The final indicator beat lands during this cycle; commit right after.
                SYNC: begin
                    config_sync <= 1'b1;
                    state       <= START;
                end

                START: begin
                    start_n <= 1'b1;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end

                ERR: begin
                    err   <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddc_config_seq.sv
// Self-checking bench for ddc_config_seq: directed scenarios plus randomized sessions
// scored against a frame-level model of the expected indicator beats and outcome.
module tb_ddc_config_seq;

    localparam int W    = 16;
    localparam int MAXW = 64;
    localparam int CLRC = 4;
    localparam int NST  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_start = 1'b0;
    logic [W-1:0]  cfg_data = '0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [W-1:0]  param_bus;
    logic [NST-1:0] stage_ind;
    logic          config_sync;
    logic          param_clr_n;
    logic          start_n;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    ddc_config_seq #(
        .COEBITWIDTH(W), .MAXWORDS(MAXW), .CLRCYCLES(CLRC), .STAGES(NST)
    ) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .param_bus(param_bus),
        .stage_ind(stage_ind), .config_sync(config_sync), .param_clr_n(param_clr_n),
        .start_n(start_n), .busy(busy), .done(done), .err(err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observed indicator beats, with the cycle on which each appeared.
    int cyc = 0;
    int q_stage[$];
    int q_data[$];
    int q_cyc[$];
    int sync_cnt = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (stage_ind != '0) begin
            q_stage.push_back(int'(stage_ind));
            q_data.push_back(int'(param_bus));
            q_cyc.push_back(cyc);
            check("onehot", $countones(stage_ind), 1);
        end
        if (config_sync) sync_cnt++;
        if (done) done_cnt++;
    end

    // Model: every accepted payload word of a well-formed frame yields one beat.
    int e_stage[$];
    int e_data[$];
    int sync_base;
    int done_base;

    function automatic bit hdr_valid(input logic [15:0] h);
        return (h[15:12] <= 4'd7) && (h[11:0] >= 12'd1) && (h[11:0] <= 12'(MAXW));
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_bus"}, param_bus, 0);
        check({tag, "_ind"}, stage_ind, 0);
        check({tag, "_sync"}, config_sync, 0);
        check({tag, "_ready"}, cfg_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_clr_n"}, param_clr_n, 1);
        check({tag, "_start_n"}, start_n, 0);
    endtask

    // Called just after a rising edge; returns just after the edge that accepted w,
    // leaving cfg_valid high so the caller can chain words back-to-back.
    task automatic send_word(input logic [15:0] w);
        cfg_data  = w;
        cfg_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cfg_ready) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("ready_timeout", cfg_ready, 1);
    endtask

    task automatic start_session();
        sync_base = sync_cnt;
        done_base = done_cnt;
        cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        for (int i = 1; i <= CLRC; i++) begin
            @(negedge clk);
            check("clr_n_low", param_clr_n, 0);
            check("ready_in_clr", cfg_ready, 0);
            check("busy_in_clr", busy, 1);
            check("start_n_in_clr", start_n, 0);
            if (i == 1) check("err_cleared", err, 0);
        end
        @(negedge clk);
        check("ready_on", cfg_ready, 1);
        check("clr_n_release", param_clr_n, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] hdr, input int gap_pct, output bit ok);
        logic [15:0] w;
        send_word(hdr);
        ok = hdr_valid(hdr);
        if (ok) begin
            for (int i = 0; i < int'(hdr[11:0]); i++) begin
                if ($urandom_range(99) < gap_pct) begin
                    cfg_valid = 1'b0;
                    @(negedge clk);
                    check("ready_in_gap", cfg_ready, 1);
                    @(posedge clk);
                    #1;
                end
                w = 16'($urandom);
                e_stage.push_back(1 << hdr[15:12]);
                e_data.push_back(int'(w));
                send_word(w);
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic finish_good();
        send_word({4'hF, 12'($urandom)});
        cfg_valid = 1'b0;
        @(negedge clk);
        check("sync_early", config_sync, 0);
        @(negedge clk);
        check("sync_pulse", config_sync, 1);
        check("start_n_before", start_n, 0);
        @(negedge clk);
        check("sync_one_cycle", config_sync, 0);
        check("start_n_rise", start_n, 1);
        check("done_pulse", done, 1);
        check("busy_fall", busy, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("start_n_hold", start_n, 1);
        check("sync_count", sync_cnt - sync_base, 1);
        check("done_count", done_cnt - done_base, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic finish_bad();
        @(negedge clk);
        @(negedge clk);
        check("err_set", err, 1);
        check("busy_fall_err", busy, 0);
        check("ready_err", cfg_ready, 0);
        repeat (3) @(negedge clk);
        check("err_sticky", err, 1);
        check("start_n_err", start_n, 0);
        check("no_sync_err", sync_cnt - sync_base, 0);
        check("no_done_err", done_cnt - done_base, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic compare_beats();
        int n;
        check("beat_count", q_stage.size(), e_stage.size());
        n = (q_stage.size() < e_stage.size()) ? q_stage.size() : e_stage.size();
        for (int i = 0; i < n; i++) begin
            check("beat_stage", q_stage[i], e_stage[i]);
            check("beat_data", q_data[i], e_data[i]);
        end
        q_stage.delete(); q_data.delete(); q_cyc.delete();
        e_stage.delete(); e_data.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        logic [15:0] fixed [3];
        logic [15:0] bad_hdr [3];
        logic [15:0] h;
        fixed   = '{16'h1111, 16'h2222, 16'h3333};
        bad_hdr = '{16'h9001, 16'h0000, 16'h0041};

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // NCO frame, back-to-back words, then end marker.
        start_session();
        send_word(16'h0003);
        for (int i = 0; i < 3; i++) begin
            e_stage.push_back(1);
            e_data.push_back(int'(fixed[i]));
            send_word(fixed[i]);
        end
        cfg_valid = 1'b0;
        finish_good();
        if (q_cyc.size() >= 3) begin
            check("b2b_beat1", q_cyc[1] - q_cyc[0], 1);
            check("b2b_beat2", q_cyc[2] - q_cyc[0], 2);
        end
        compare_beats();

        // FIR frame with a gap before every word.
        start_session();
        send_frame(16'h6002, 100, ok);
        finish_good();
        if (q_cyc.size() >= 2) check("gap_beats", q_cyc[1] - q_cyc[0], 2);
        compare_beats();

        // Invalid headers, the last one after a good frame.
        for (int k = 0; k < 3; k++) begin
            start_session();
            if (k == 2) send_frame(16'h3002, 0, ok);
            send_frame(bad_hdr[k], 0, ok);
            finish_bad();
            compare_beats();
        end

        // Reset while the second of four words is being offered.
        start_session();
        send_word(16'h2004);
        e_stage.push_back(1 << 2);
        e_data.push_back(16'hA5A5);
        send_word(16'hA5A5);
        cfg_data = 16'h5A5A;
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset_vals("midrst");
        cfg_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_ind", stage_ind, 0);
            check("post_rst_ready", cfg_ready, 0);
            check("post_rst_busy", busy, 0);
        end
        check("post_rst_no_sync", sync_cnt - sync_base, 0);
        @(posedge clk);
        #1;
        compare_beats();

        // Full-length frame after the reset, plus a second frame to the same stage.
        start_session();
        send_frame(16'h7040, 10, ok);
        send_frame(16'h7001, 0, ok);
        finish_good();
        compare_beats();

        // cfg_start pulsed mid-DATA must be ignored.
        start_session();
        send_word(16'h1003);
        for (int i = 0; i < 3; i++) begin
            h = 16'($urandom);
            e_stage.push_back(1 << 1);
            e_data.push_back(int'(h));
            if (i == 1) cfg_start = 1'b1;
            send_word(h);
            cfg_start = 1'b0;
        end
        cfg_valid = 1'b0;
        finish_good();
        compare_beats();

        // Randomized sessions.
        for (int s = 0; s < 10; s++) begin
            int nfr;
            bit bad_seen;
            nfr = $urandom_range(1, 3);
            bad_seen = 1'b0;
            start_session();
            for (int f = 0; f < nfr && !bad_seen; f++) begin
                if ($urandom_range(99) < 15) begin
                    case ($urandom_range(2))
                        0: h = {4'($urandom_range(8, 14)), 12'($urandom_range(1, MAXW))};
                        1: h = {4'($urandom_range(0, 7)), 12'h000};
                        default: h = {4'($urandom_range(0, 7)), 12'($urandom_range(MAXW + 1, 4095))};
                    endcase
                end else begin
                    h = {4'($urandom_range(0, 7)),
                         ($urandom_range(4) == 0) ? 12'(MAXW) : 12'($urandom_range(1, 6))};
                end
                send_frame(h, $urandom_range(0, 50), ok);
                if (!ok) bad_seen = 1'b1;
            end
            if (bad_seen) finish_bad();
            else finish_good();
            compare_beats();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
